// File: rtl/serial_word_rx.sv
// Serial-to-parallel receiver: rebuilds MSB-first SIZE-bit words from a bit
// stream and hands them out through a 2-entry valid/ready buffer.
module serial_word_rx #(
  parameter int SIZE = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  en,
  input  logic                  serIn,
  input  logic                  sync,
  output logic [SIZE-1:0]       dataOut,
  output logic                  valid,
  input  logic                  ready,
  output logic [$clog2(SIZE):0] bitCnt,
  output logic                  overrun,
  input  logic                  clrErr
);

  localparam int CW = $clog2(SIZE) + 1;

  typedef enum logic [1:0] {EMPTY, ONE, FULL} buf_state_t;

  buf_state_t      state, state_n;
  logic [SIZE-2:0] acc;  // the oldest assembled bit never reaches a word, so it is not stored
  logic [SIZE-1:0] word, head, tail, head_n, tail_n;
  logic            push, pop, drop;

  assign word    = {acc, serIn};
  assign push    = en && !sync && (bitCnt == CW'(SIZE - 1));
  assign valid   = (state != EMPTY);
  assign pop     = valid && ready;
  assign dataOut = valid ? head : '0;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc    <= '0;
      bitCnt <= '0;
    end else if (en) begin
      acc <= word[SIZE-2:0];
      if (sync)
        bitCnt <= CW'(1);
      else if (push)
        bitCnt <= '0;
      else
        bitCnt <= bitCnt + CW'(1);
    end else if (sync) begin
      bitCnt <= '0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= EMPTY;
      head    <= '0;
      tail    <= '0;
      overrun <= 1'b0;
    end else begin
      state <= state_n;
      head  <= head_n;
      tail  <= tail_n;
      if (drop)
        overrun <= 1'b1;
      else if (clrErr)
        overrun <= 1'b0;
    end
  end

  always_comb begin
    state_n = state;
    head_n  = head;
    tail_n  = tail;
    drop    = 1'b0;
    case (state)
      EMPTY: begin
        if (push) begin
          head_n  = word;
          state_n = ONE;
        end
      end
      ONE: begin
        if (push && pop) begin
          head_n = word;
        end else if (push) begin
          tail_n  = word;
          state_n = FULL;
        end else if (pop) begin
          state_n = EMPTY;
        end
      end
      FULL: begin
        if (push && pop) begin
          head_n = tail;
          tail_n = word;
        end else if (pop) begin
          head_n  = tail;
          state_n = ONE;
        end else if (push) begin
          drop = 1'b1;
        end
      end
      default: state_n = EMPTY;
    endcase
  end

endmodule

// File: tb/tb_serial_word_rx.sv
// Randomized and directed bench for serial_word_rx with a queue-based
// reference model and a monitor that consumes words as the DUT offers them.
module tb_serial_word_rx;

  localparam int SIZE = 8;

  logic                  clk = 1'b0;
  logic                  rst = 1'b1;
  logic                  en = 1'b0, serIn = 1'b0, sync = 1'b0, ready = 1'b0, clrErr = 1'b0;
  logic [SIZE-1:0]       dataOut;
  logic                  valid;
  logic [$clog2(SIZE):0] bitCnt;
  logic                  overrun;

  serial_word_rx #(.SIZE(SIZE)) dut (
    .clk(clk), .rst(rst), .en(en), .serIn(serIn), .sync(sync),
    .dataOut(dataOut), .valid(valid), .ready(ready),
    .bitCnt(bitCnt), .overrun(overrun), .clrErr(clrErr)
  );

  always #5 clk = ~clk;

  // Reference model: bits collected since the last frame start, plus the
  // contents of a 2-deep output buffer.
  logic [SIZE-1:0] q[$];
  int              cnt = 0;
  logic [31:0]     acc_w = 0;
  logic            exp_ovr = 1'b0;
  int              n_chk = 0, n_fail = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: inputs settle 1 time unit after posedge, so the falling edge
  // sees the values that the next rising edge will act on.
  always @(negedge clk) begin
    if (!rst) begin
      chk("valid", {31'b0, valid}, {31'b0, q.size() != 0});
      if (q.size() == 0) begin
        chk("dataOut_idle", {24'b0, dataOut}, 32'h0);
      end else if (ready) begin
        chk("dataOut_pop", {24'b0, dataOut}, {24'b0, q[0]});
        void'(q.pop_front());
      end
    end
  end

  task automatic step(input logic e, input logic b, input logic s, input logic r, input logic c);
    logic dropped;
    en = e; serIn = b; sync = s; ready = r; clrErr = c;
    @(posedge clk); #1;
    dropped = 1'b0;
    if (e) begin
      if (s) begin
        acc_w = {31'b0, b};
        cnt   = 1;
      end else begin
        acc_w = (acc_w << 1) | {31'b0, b};
        cnt++;
        if (cnt == SIZE) begin
          if (q.size() < 2) q.push_back(acc_w[SIZE-1:0]);
          else dropped = 1'b1;
          cnt   = 0;
          acc_w = 0;
        end
      end
    end else if (s) begin
      cnt   = 0;
      acc_w = 0;
    end
    if (dropped) exp_ovr = 1'b1;
    else if (c) exp_ovr = 1'b0;
    chk("bitCnt", {28'b0, bitCnt}, cnt);
    chk("overrun", {31'b0, overrun}, {31'b0, exp_ovr});
  endtask

  task automatic send_word(input logic [SIZE-1:0] w, input logic r);
    for (int i = SIZE - 1; i >= 0; i--) step(1'b1, w[i], 1'b0, r, 1'b0);
  endtask

  task automatic idle(input int n, input logic r);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b0, r, 1'b0);
  endtask

  // Asserted between edges to exercise the asynchronous path.
  task automatic do_reset();
    en = 1'b0; sync = 1'b0; clrErr = 1'b0; ready = 1'b0;
    #1 rst = 1'b1;
    #1;
    chk("rst_valid", {31'b0, valid}, 32'h0);
    chk("rst_bitCnt", {28'b0, bitCnt}, 32'h0);
    chk("rst_dataOut", {24'b0, dataOut}, 32'h0);
    chk("rst_overrun", {31'b0, overrun}, 32'h0);
    q.delete();
    cnt = 0; acc_w = 0; exp_ovr = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

  initial begin
    logic [SIZE-1:0] w;
    int n;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    chk("reset_valid", {31'b0, valid}, 32'h0);
    chk("reset_dataOut", {24'b0, dataOut}, 32'h0);
    chk("reset_bitCnt", {28'b0, bitCnt}, 32'h0);
    chk("reset_overrun", {31'b0, overrun}, 32'h0);

    // Single word, one-edge latency, then pop.
    send_word(8'hAA, 1'b1);
    chk("lat_valid", {31'b0, valid}, 32'h1);
    chk("lat_dataOut", {24'b0, dataOut}, 32'hAA);
    idle(1, 1'b1);
    chk("after_pop_valid", {31'b0, valid}, 32'h0);
    chk("after_pop_dataOut", {24'b0, dataOut}, 32'h0);

    // Overrun with ready low; third word is dropped.
    send_word(8'hAA, 1'b0);
    send_word(8'h55, 1'b0);
    send_word(8'h0F, 1'b0);
    chk("ovr_set", {31'b0, overrun}, 32'h1);
    idle(3, 1'b1);
    step(1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
    chk("ovr_clr", {31'b0, overrun}, 32'h0);

    // Sync mid-word restarts the frame.
    for (int i = 0; i < 3; i++) step(1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
    w = 8'h3C;
    step(1'b1, w[7], 1'b1, 1'b1, 1'b0);
    chk("sync_bitCnt", {28'b0, bitCnt}, 32'h1);
    for (int i = 6; i >= 0; i--) step(1'b1, w[i], 1'b0, 1'b1, 1'b0);
    idle(2, 1'b1);

    // Push and pop together while FULL.
    send_word(8'h11, 1'b0);
    send_word(8'h22, 1'b0);
    w = 8'h33;
    for (int i = 7; i >= 0; i--) step(1'b1, w[i], 1'b0, i == 0, 1'b0);
    chk("full_pushpop_ovr", {31'b0, overrun}, 32'h0);
    idle(3, 1'b1);

    // Reset mid-word with a word buffered.
    send_word(8'h5A, 1'b0);
    for (int i = 0; i < 5; i++) step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    do_reset();
    send_word(8'hC3, 1'b1);
    idle(2, 1'b1);

    // Set beats clear on the same edge.
    send_word(8'h01, 1'b0);
    send_word(8'h02, 1'b0);
    send_word(8'h03, 1'b0);
    w = 8'h04;
    for (int i = 7; i >= 0; i--) step(1'b1, w[i], 1'b0, 1'b0, i == 0);
    chk("ovr_priority", {31'b0, overrun}, 32'h1);
    idle(3, 1'b1);
    step(1'b0, 1'b0, 1'b0, 1'b1, 1'b1);

    // Random traffic.
    for (int i = 0; i < 600; i++)
      step($urandom_range(3, 0) != 0, 1'($urandom), $urandom_range(15, 0) == 0,
           1'($urandom), $urandom_range(15, 0) == 0);

    n = 0;
    while (q.size() != 0 && n < 20) begin
      idle(1, 1'b1);
      n++;
    end
    chk("drain", q.size(), 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
